// File: rtl/rv32m_muldiv_unit_pkg.sv
// M_Inst_Pkg: RV32M funct3 codes, mul/div FSM states and shared constants.
package M_Inst_Pkg;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;
  localparam int MULDIV_ITER = 32;
  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFFFFFF;
  localparam logic [31:0] DIV_OVF_Q     = 32'h80000000;
  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, SPECIAL} muldiv_state_e;
endpackage

// File: rtl/rv32m_muldiv_unit_divider.sv
// rv_serial_divider: unsigned 32-step restoring divider; mul=1 reuses counter and {hi,lo} for shift-add multiply.
module rv_serial_divider
  import M_Inst_Pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        start,
  input  logic        mul,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [63:0] acc
);
  logic [4:0] cnt;
  logic run, ge;
  logic [31:0] d, sub;
  logic [32:0] sum;
  logic [63:0] step;
  always_comb begin
    ge   = {1'b0, acc[63:31]} >= {2'b0, d};
    sub  = acc[62:31] - d;
    sum  = {1'b0, acc[63:32]} + {1'b0, d};
    step = mul ? {acc[0] ? sum : {1'b0, acc[63:32]}, acc[31:1]}
               : (ge ? {sub, acc[30:0], 1'b1} : {acc[62:0], 1'b0});
  end
  assign done = run && cnt == 5'd0;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      run <= 1'b0;
      cnt <= 5'd0;
      acc <= '0;
      d   <= '0;
    end else if (start) begin
      acc <= {32'd0, a};
      d   <= b;
      cnt <= 5'(MULDIV_ITER - 1);
      run <= 1'b1;
    end else if (run) begin
      acc <= step;
      cnt <= done ? 5'd0 : cnt - 5'd1;
      run <= !done;
    end
  end
endmodule

// File: rtl/rv32m_muldiv_unit.sv
// rv32m_muldiv_unit: multi-cycle RV32M MUL/DIV unit; define RV32M_FAST_MUL_EN for a single-stage 33x33 multiplier.
module rv32m_muldiv_unit
  import M_Inst_Pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  muldiv_state_e st, st_n;
  logic first, neg_a, neg_b, start, done, ov_n;
  logic a_s, b_s, na, nb, zero, ovf, special, accept;
  logic [2:0] f3;
  logic [31:0] ma, mb, sres, res_n, fix_res, q, r;
  logic [63:0] acc, p;
  assign accept   = in_valid && st == IDLE && !flush;
  assign in_ready = st == IDLE;
  assign busy     = st != IDLE;
  assign a_s      = !(funct3 inside {F3_MUL, F3_MULHU, F3_DIVU, F3_REMU});
  assign b_s      = funct3 inside {F3_MULH, F3_DIV, F3_REM};
  assign na       = a_s && rs1[31];
  assign nb       = b_s && rs2[31];
  assign zero     = rs2 == '0;
  assign ovf      = b_s && rs1 == DIV_OVF_Q && rs2 == DIV_BY_ZERO_Q;
  assign special  = funct3[2] && (zero || ovf);
  assign q        = acc[31:0];
  assign r        = acc[63:32];
`ifdef RV32M_FAST_MUL_EN
  logic signed [32:0] fa, fb;
  logic [63:0] prod;
  assign p = prod;
  always_ff @(posedge clk) begin
    if (rst) begin
      fa   <= '0;
      fb   <= '0;
      prod <= '0;
    end else begin
      if (accept) begin
        fa <= {na, rs1};
        fb <= {nb, rs2};
      end
      if (st == MUL) prod <= 64'(66'(fa) * 66'(fb));
    end
  end
`else
  assign p = (neg_a ^ neg_b) ? -acc : acc;
`endif
  assign fix_res = !f3[2] ? (f3 == F3_MUL ? p[31:0] : p[63:32])
                 : f3[1] ? (neg_a ? -r : r)
                 : ((neg_a ^ neg_b) ? -q : q);
  rv_serial_divider u_div (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .start(start),
    .mul  (!f3[2]),
    .a    (ma),
    .b    (mb),
    .done (done),
    .acc  (acc)
  );
  // The first cycle after accept is an operand-settling slot in every busy state.
  always_comb begin
    st_n  = st;
    ov_n  = 1'b0;
    res_n = result;
    start = 1'b0;
    unique case (st)
      IDLE: st_n = accept ? (special ? SPECIAL : funct3[2] ? DIV : MUL) : IDLE;
`ifdef RV32M_FAST_MUL_EN
      MUL: st_n = first ? MUL : FIX;
`else
      MUL: begin
        start = first;
        st_n  = done ? FIX : MUL;
      end
`endif
      DIV: begin
        start = first;
        st_n  = done ? FIX : DIV;
      end
      FIX: begin
        st_n  = IDLE;
        ov_n  = 1'b1;
        res_n = fix_res;
      end
      SPECIAL: begin
        st_n  = first ? SPECIAL : IDLE;
        ov_n  = !first;
        res_n = first ? result : sres;
      end
      default: st_n = IDLE;
    endcase
    if (flush) begin
      st_n  = IDLE;
      ov_n  = 1'b0;
      res_n = result;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      first     <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      f3        <= '0;
      neg_a     <= 1'b0;
      neg_b     <= 1'b0;
      ma        <= '0;
      mb        <= '0;
      sres      <= '0;
    end else begin
      st        <= st_n;
      first     <= accept;
      out_valid <= ov_n;
      result    <= res_n;
      if (accept) begin
        f3    <= funct3;
        neg_a <= na;
        neg_b <= nb;
        ma    <= na ? -rs1 : rs1;
        mb    <= nb ? -rs2 : rs2;
        sres  <= funct3[1] ? (zero ? rs1 : 32'd0) : (zero ? DIV_BY_ZERO_Q : DIV_OVF_Q);
      end
    end
  end
endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// tb_rv32m_muldiv_unit: directed vectors checked against an arithmetic RV32M model and per-cycle protocol checks.
module tb_rv32m_muldiv_unit;
`ifdef RV32M_FAST_MUL_EN
  localparam int ML = 3;
`else
  localparam int ML = 34;
`endif
  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    int          lat;
  } vec_t;
  logic clk = 0, rst = 1, in_valid = 0, flush = 0;
  logic [2:0] funct3 = '0;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic in_ready, out_valid, busy, rst_q;
  logic [31:0] result;
  int tests = 0, fails = 0, cyc = 0, k = 0, due = 0, dprev;
  logic pend = 0, chk_en = 0;
  logic [31:0] exp_res = '0, held = '0;
  vec_t v[$];
  rv32m_muldiv_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .flush(flush), .out_valid(out_valid), .result(result), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'd0, a});
    longint ub = longint'({32'd0, b});
    logic ov = a == 32'h80000000 && b == 32'hFFFFFFFF;
    logic [63:0] p;
    case (f)
      3'd0: begin p = 64'(ua * ub); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: return b == 0 ? 32'hFFFFFFFF : ov ? a : 32'(sa / sb);
      3'd5: return b == 0 ? 32'hFFFFFFFF : a / b;
      3'd6: return b == 0 ? a : ov ? 32'd0 : 32'(sa % sb);
      default: return b == 0 ? a : a % b;
    endcase
  endfunction
  function automatic int lat_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return ML;
    return (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)) ? 2 : 34;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (chk_en) begin
      if (rst_q) held = '0;
      if (pend && cyc == due) held = exp_res;
      chk("out_valid", out_valid, pend && cyc == due);
      chk("result_hold", result, held);
      chk("in_ready", in_ready, !pend || cyc >= due);
      chk("busy", busy, pend && cyc < due);
    end
  end
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    funct3 = f; rs1 = a; rs2 = b; in_valid = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    k = cyc; pend = 1; due = cyc + lat_model(f, a, b); exp_res = model(f, a, b);
    @(negedge clk);
  endtask
  task automatic wait_done(input string nm, input logic [31:0] lit, input int lat);
    int n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_res"}, result, lit);
    chk({nm, "_lat"}, cyc - k, lat);
  endtask
  initial begin
    v.push_back('{3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34});
    v.push_back('{3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34});
    v.push_back('{3'b101, 32'd100, 32'd0, 32'hFFFFFFFF, 2});
    v.push_back('{3'b111, 32'd100, 32'd0, 32'd100, 2});
    v.push_back('{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2});
    v.push_back('{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 2});
    v.push_back('{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, ML});
    v.push_back('{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, ML});
    v.push_back('{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, ML});
    v.push_back('{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, ML});
    v.push_back('{3'b101, 32'd100, 32'd7, 32'd14, 34});
    v.push_back('{3'b111, 32'd100, 32'd7, 32'd2, 34});
    v.push_back('{3'b100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 34});
    v.push_back('{3'b110, 32'd7, 32'hFFFFFFFE, 32'd1, 34});
    v.push_back('{3'b000, 32'h12345678, 32'h10, 32'h23456780, ML});
    v.push_back('{3'b100, 32'd5, 32'd0, 32'hFFFFFFFF, 2});
    v.push_back('{3'b110, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 2});
    v.push_back('{3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0, 34});
    v.push_back('{3'b001, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, ML});
    repeat (3) @(negedge clk);
    rst = 0;
    chk("rst_result", result, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk_en = 1;
    foreach (v[i]) begin
      chk($sformatf("model%0d", i), model(v[i].f, v[i].a, v[i].b), v[i].r);
      do_op(v[i].f, v[i].a, v[i].b);
      wait_done($sformatf("vec%0d", i), v[i].r, v[i].lat);
    end
    in_valid = 1; flush = 1; funct3 = 3'b100; rs1 = 32'd9; rs2 = 32'd2;
    @(posedge clk);
    #1;
    in_valid = 0; flush = 0;
    @(negedge clk);
    chk("flush_idle_no_accept", {in_ready, busy}, 2'b10);
    do_op(3'b100, 32'd1000, 32'd3);
    while (cyc != k + 10) @(negedge clk);
    flush = 1;
    @(posedge clk);
    #1;
    flush = 0; pend = 0;
    @(negedge clk);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_result", result, v[v.size() - 1].r);
    repeat (30) begin
      @(negedge clk);
      chk("flush_no_ov", out_valid, 0);
    end
    do_op(3'b100, 32'd1000, 32'd3);
    wait_done("after_flush", 32'd333, 34);
    do_op(3'b100, 32'd50, 32'd7);
    while (cyc != k + 5) @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0; pend = 0;
    @(negedge clk);
    chk("midrst_result", result, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    do_op(3'b011, 32'hFFFFFFFF, 32'd2);
    wait_done("b2b_a", 32'd1, ML);
    dprev = cyc;
    do_op(3'b111, 32'd50, 32'd7);
    chk("b2b_no_bubble", k, dprev + 1);
    wait_done("b2b_b", 32'd1, 34);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
